link_ctrl: RTL

// - Reader transaction sequencer between host logic and the TX (FM0 encoder) / RX (preamble+symbol decoder) datapaths.
// - Serialises one command to the encoder, waits the T1 turnaround, arms the receiver, and collects a fixed-length tag reply.
// - On completion it reports done or timeout. It sits in top between the command source and the tx/rx chains.

---
 rtl/link_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/link_ctrl.sv
// ============================================================================
//  Module   : link_ctrl
//  Purpose  : Reader transaction sequencer. Serialises one command to the
//             FM0 encoder, waits the T1 turnaround, arms the receiver and
//             collects a fixed-length tag reply, then reports done/timeout.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             start, abort          - host request / forced return to IDLE
//             cmd_data/len, rsp_len - command word (MSB first) and lengths
//             tx_bit/vld, tx_rdy    - bit stream to the encoder
//             tx_idle               - encoder finished its last symbol
//             rx_en                 - receiver armed
//             pre_det, rx_bit/vld   - preamble pulse and decoded reply bits
//             rsp_bit/vld           - registered reply bits to the host
//             busy, done, timeout   - status and completion pulses
//  Option   : RETRY_EN - retransmit the command on preamble timeout, up to
//             MAX_RETRY times, before reporting timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_ctrl #(
    parameter int CMD_WIDTH   = 32,
    parameter int LEN_WIDTH   = 6,
    parameter int RSP_WIDTH   = 8,
    parameter int T1_CYCLES   = 40,
    parameter int PRE_TIMEOUT = 4000,
    parameter int BIT_TIMEOUT = 400,
    parameter int MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CMD_WIDTH-1:0] cmd_data,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [RSP_WIDTH-1:0] rsp_len,
    output logic                 tx_bit,
    output logic                 tx_vld,
    input  logic                 tx_rdy,
    input  logic                 tx_idle,
    output logic                 rx_en,
    input  logic                 pre_det,
    input  logic                 rx_bit,
    input  logic                 rx_vld,
    output logic                 rsp_bit,
    output logic                 rsp_vld,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    localparam int T1_W  = $clog2(T1_CYCLES + 1);
    localparam int PRE_W = $clog2(PRE_TIMEOUT + 1);
    localparam int BIT_W = $clog2(BIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TX     = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_T1     = 3'd3,
        ST_LISTEN = 3'd4,
        ST_RECV   = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nx;

    logic [CMD_WIDTH-1:0]   shreg;
    logic [LEN_WIDTH-1:0]   bit_cnt;
    logic [RSP_WIDTH-1:0]   rsp_len_q;
    logic [RSP_WIDTH-1:0]   rx_cnt;
    logic [RSP_WIDTH:0]     rx_cnt_inc;
    logic [T1_W-1:0]        t1_cnt;
    logic [PRE_W-1:0]       pre_cnt;
    logic [BIT_W-1:0]       bit_tmr;

    logic                   load_cmd;
    logic                   tx_xfer;
    logic                   rx_take;
    logic                   done_nx;
    logic                   timeout_nx;
    logic                   t1_over;
    logic                   pre_expired;
    logic                   bit_expired;
    logic                   rx_last;

`ifdef RETRY_EN
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [CMD_WIDTH-1:0]   cmd_q;
    logic [LEN_WIDTH-1:0]   cmd_len_q;
    logic [RTY_W-1:0]       retries;
    logic                   retry;
`endif

    assign busy        = (state != ST_IDLE);
    assign t1_over     = (t1_cnt  >= T1_W'(T1_CYCLES - 1));
    assign pre_expired = (pre_cnt >= PRE_W'(PRE_TIMEOUT - 1));
    assign bit_expired = (bit_tmr >= BIT_W'(BIT_TIMEOUT - 1));
    assign rx_cnt_inc  = {1'b0, rx_cnt} + {{RSP_WIDTH{1'b0}}, 1'b1};
    // The bit being accepted this cycle completes the reply.
    assign rx_last     = (rx_cnt_inc >= {1'b0, rsp_len_q});

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        load_cmd   = 1'b0;
        tx_xfer    = 1'b0;
        rx_take    = 1'b0;
        done_nx    = 1'b0;
        timeout_nx = 1'b0;
        tx_vld     = 1'b0;
        tx_bit     = 1'b0;
        rx_en      = 1'b0;
`ifdef RETRY_EN
        retry      = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_cmd = 1'b1;
                    state_nx = (cmd_len != '0) ? ST_TX : ST_T1;
                end
            end
            ST_TX: begin
                tx_vld = 1'b1;
                tx_bit = shreg[CMD_WIDTH-1];
                if (tx_rdy) begin
                    tx_xfer = 1'b1;
                    if (bit_cnt <= LEN_WIDTH'(1)) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (tx_idle) begin
                    state_nx = ST_T1;
                end
            end
            ST_T1: begin
                if (t1_over) begin
                    state_nx = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                rx_en = 1'b1;
                // A preamble on the expiry cycle still counts as found.
                if (pre_det) begin
                    if (rsp_len_q == '0) begin
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_RECV;
                    end
                end else if (pre_expired) begin
`ifdef RETRY_EN
                    if (retries < RTY_W'(MAX_RETRY)) begin
                        retry    = 1'b1;
                        state_nx = (cmd_len_q != '0) ? ST_TX : ST_T1;
                    end else begin
                        timeout_nx = 1'b1;
                        state_nx   = ST_IDLE;
                    end
`else
                    timeout_nx = 1'b1;
                    state_nx   = ST_IDLE;
`endif
                end
            end
            ST_RECV: begin
                rx_en = 1'b1;
                if (rx_vld) begin
                    rx_take = 1'b1;
                    if (rx_last) begin
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end else if (bit_expired) begin
                    timeout_nx = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Abort overrides every event; outputs of the current cycle stand,
        // but nothing is loaded, counted or reported.
        if (abort) begin
            state_nx   = ST_IDLE;
            load_cmd   = 1'b0;
            tx_xfer    = 1'b0;
            rx_take    = 1'b0;
            done_nx    = 1'b0;
            timeout_nx = 1'b0;
`ifdef RETRY_EN
            retry      = 1'b0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, counters, registered reply outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            rsp_len_q <= '0;
            rx_cnt    <= '0;
            t1_cnt    <= '0;
            pre_cnt   <= '0;
            bit_tmr   <= '0;
            rsp_vld   <= 1'b0;
            rsp_bit   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            done    <= done_nx;
            timeout <= timeout_nx;
            rsp_vld <= rx_take;
            rsp_bit <= rx_take & rx_bit;

            if (load_cmd) begin
                shreg     <= cmd_data;
                bit_cnt   <= cmd_len;
                rsp_len_q <= rsp_len;
`ifdef RETRY_EN
            end else if (retry) begin
                shreg   <= cmd_q;
                bit_cnt <= cmd_len_q;
`endif
            end else if (tx_xfer) begin
                shreg <= {shreg[CMD_WIDTH-2:0], 1'b0};
                if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end

            if (load_cmd) begin
                rx_cnt <= '0;
            end else if (rx_take && (rx_cnt != '1)) begin
                rx_cnt <= rx_cnt + 1'b1;
            end

            // Each timer runs only while the FSM stays in its own state,
            // so it starts from zero on every entry.
            if ((state == ST_T1) && (state_nx == ST_T1)) begin
                if (t1_cnt != '1) t1_cnt <= t1_cnt + 1'b1;
            end else begin
                t1_cnt <= '0;
            end

            if ((state == ST_LISTEN) && (state_nx == ST_LISTEN)) begin
                if (pre_cnt != '1) pre_cnt <= pre_cnt + 1'b1;
            end else begin
                pre_cnt <= '0;
            end

            if ((state == ST_RECV) && (state_nx == ST_RECV) && !rx_take) begin
                if (bit_tmr != '1) bit_tmr <= bit_tmr + 1'b1;
            end else begin
                bit_tmr <= '0;
            end
        end
    end

`ifdef RETRY_EN
    // ------------------------------------------------------------------
    // Retry bookkeeping: copy of the command for retransmission
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            cmd_len_q <= '0;
            retries   <= '0;
        end else begin
            if (load_cmd) begin
                cmd_q     <= cmd_data;
                cmd_len_q <= cmd_len;
            end
            if (state == ST_IDLE) begin
                retries <= '0;
            end else if (retry && (retries != '1)) begin
                retries <= retries + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
